// File: rtl/hvac_sequencer.sv
// rtl/hvac_sequencer.sv - heating/cooling plant sequencer with hysteresis, min run/off and fan overrun
module hvac_sequencer #(
    parameter int TICK_DIV    = 100000000,
    parameter int HYST        = 1,
    parameter int MIN_RUN     = 5,
    parameter int MIN_OFF     = 3,
    parameter int FAN_OVERRUN = 2
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic [7:0] CurrentTemp,
    input  logic [7:0] DesiredTemp,
    output logic       Heat,
    output logic       Cool,
    output logic       Fan,
    output logic [2:0] State,
    output logic       Tick
);

    localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX    = (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int FW      = (FAN_OVERRUN > 0) ? $clog2(FAN_OVERRUN + 1) : 1;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HEAT    = 3'd2,
        ST_COOL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] pre_cnt;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic [FW-1:0] fan_cnt;
    logic [FW-1:0] next_fan_cnt;
    logic          timer_load;
    logic          fan_load;
    logic          heat_req;
    logic          cool_req;
    logic [9:0]    cur_ext;
    logic [9:0]    des_ext;

    // Tick is decoded from the prescaler register only, so it never sees an input
    assign Tick  = (pre_cnt == PW'(TICK_DIV - 1));
    assign State = state;

    // Widen before adding the band so 255 + HYST cannot wrap
    assign cur_ext  = {2'b00, CurrentTemp};
    assign des_ext  = {2'b00, DesiredTemp};
    assign heat_req = (cur_ext + 10'(HYST)) < des_ext;
    assign cool_req = cur_ext > (des_ext + 10'(HYST));

    // Free-running time-base prescaler
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pre_cnt <= '0;
        end else if (Tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Next-state decode; timer loads mark state entry
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        fan_load   = 1'b0;
        next_timer = timer;
        case (state)
            ST_OFF: begin
                if (Enable) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (!Enable) begin
                    next_state = ST_OFF;
                end else if (heat_req) begin
                    next_state = ST_HEAT;
                    timer_load = 1'b1;
                    next_timer = TW'(MIN_RUN);
                end else if (cool_req) begin
                    next_state = ST_COOL;
                    timer_load = 1'b1;
                    next_timer = TW'(MIN_RUN);
                end
            end
            ST_HEAT: begin
                if (timer == '0 && (CurrentTemp >= DesiredTemp || !Enable)) begin
                    next_state = ST_LOCKOUT;
                    timer_load = 1'b1;
                    fan_load   = 1'b1;
                    next_timer = TW'(MIN_OFF);
                end
            end
            ST_COOL: begin
                if (timer == '0 && (CurrentTemp <= DesiredTemp || !Enable)) begin
                    next_state = ST_LOCKOUT;
                    timer_load = 1'b1;
                    fan_load   = 1'b1;
                    next_timer = TW'(MIN_OFF);
                end
            end
            ST_LOCKOUT: begin
                if (timer == '0) next_state = Enable ? ST_IDLE : ST_OFF;
            end
            default: begin
                next_state = ST_OFF;
            end
        endcase
        if (!timer_load && Tick && timer != '0) next_timer = timer - 1'b1;
    end

    // Fan overrun counter: loaded when a heat/cool cycle ends, counts down on Tick
    always_comb begin
        next_fan_cnt = fan_cnt;
        if (fan_load) begin
            next_fan_cnt = FW'(FAN_OVERRUN);
        end else if (Tick && fan_cnt != '0) begin
            next_fan_cnt = fan_cnt - 1'b1;
        end
    end

    // State, timers and registered plant drives share one edge
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_OFF;
            timer   <= '0;
            fan_cnt <= '0;
            Heat    <= 1'b0;
            Cool    <= 1'b0;
            Fan     <= 1'b0;
        end else begin
            state   <= next_state;
            timer   <= next_timer;
            fan_cnt <= next_fan_cnt;
            Heat    <= (next_state == ST_HEAT);
            Cool    <= (next_state == ST_COOL);
            Fan     <= (next_state == ST_HEAT) || (next_state == ST_COOL) || (next_fan_cnt != '0);
        end
    end

endmodule

// File: tb/tb_hvac_sequencer.sv
// tb/tb_hvac_sequencer.sv - directed self-checking bench for hvac_sequencer
module tb_hvac_sequencer;

    logic       clk;
    logic       Reset_n;
    logic       Enable;
    logic [7:0] CurrentTemp;
    logic [7:0] DesiredTemp;
    logic       Heat;
    logic       Cool;
    logic       Fan;
    logic [2:0] State;
    logic       Tick;

    int errors;
    int checks;
    int cyc;

    hvac_sequencer #(
        .TICK_DIV(4), .HYST(1), .MIN_RUN(3), .MIN_OFF(2), .FAN_OVERRUN(2)
    ) dut (
        .clk(clk), .Reset_n(Reset_n), .Enable(Enable),
        .CurrentTemp(CurrentTemp), .DesiredTemp(DesiredTemp),
        .Heat(Heat), .Cool(Cool), .Fan(Fan), .State(State), .Tick(Tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to just after rising edge n (counted from reset release), sampling on the falling edge
    task automatic clk_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic drives(input string tag, input int st, input int h, input int c, input int f);
        check({tag, ".state"}, int'(State), st);
        check({tag, ".heat"}, int'(Heat), h);
        check({tag, ".cool"}, int'(Cool), c);
        check({tag, ".fan"}, int'(Fan), f);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        Reset_n = 1'b0;
        Enable = 1'b0;
        CurrentTemp = 8'd22;
        DesiredTemp = 8'd22;

        // 1: reset state, prescaler phase, OFF -> IDLE
        repeat (2) @(negedge clk);
        drives("rst", 0, 0, 0, 0);
        check("rst.tick", int'(Tick), 0);
        Reset_n = 1'b1;
        clk_to(1);  check("t1.tick", int'(Tick), 0);  check("t1.state", int'(State), 0);
        clk_to(2);  check("t2.tick", int'(Tick), 0);
        clk_to(3);  check("t3.tick", int'(Tick), 1);
        clk_to(4);  check("t4.tick", int'(Tick), 0);  check("t4.state", int'(State), 0);
        Enable = 1'b1;
        clk_to(5);  drives("idle", 1, 0, 0, 0);

        // 2: heat cycle with min-run hold, lockout and fan overrun
        CurrentTemp = 8'd20;
        clk_to(6);  drives("heat_in", 2, 1, 0, 1);
        clk_to(8);  CurrentTemp = 8'd23;
        clk_to(16); drives("heat_hold", 2, 1, 0, 1);
        clk_to(17); drives("heat_lock", 4, 0, 0, 1);
        clk_to(23); drives("lock_fan", 4, 0, 0, 1);
        clk_to(24); drives("lock_fanoff", 4, 0, 0, 0);
        clk_to(25); drives("lock_idle", 1, 0, 0, 0);

        // 3: inside the band, then 4: width boundaries with no wrap
        CurrentTemp = 8'd21;
        clk_to(27); check("band.state", int'(State), 1);
        CurrentTemp = 8'd255; DesiredTemp = 8'd254;
        clk_to(28); check("hi_edge.state", int'(State), 1);
        CurrentTemp = 8'd0; DesiredTemp = 8'd1;
        clk_to(29); check("lo_edge.state", int'(State), 1);

        // 3/5: cooling, Enable dropped after one tick does not shorten min-run
        CurrentTemp = 8'd24; DesiredTemp = 8'd22;
        clk_to(30); drives("cool_in", 3, 0, 1, 1);
        clk_to(32); Enable = 1'b0;
        clk_to(40); drives("cool_hold", 3, 0, 1, 1);
        clk_to(41); drives("cool_lock", 4, 0, 0, 1);
        clk_to(47); drives("cool_fan", 4, 0, 0, 1);
        clk_to(48); drives("cool_fanoff", 4, 0, 0, 0);
        clk_to(49); drives("cool_off", 0, 0, 0, 0);

        // 4: full-range heat request
        Enable = 1'b1;
        clk_to(50); check("reidle.state", int'(State), 1);
        CurrentTemp = 8'd0; DesiredTemp = 8'd255;
        clk_to(51); drives("wide_heat", 2, 1, 0, 1);

        // 6: asynchronous reset mid-HEAT, then a fresh min-run
        #2 Reset_n = 1'b0;
        #1 drives("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        Reset_n = 1'b1;
        cyc = 0;
        clk_to(1);  drives("post_idle", 1, 0, 0, 0);
        clk_to(2);  drives("post_heat", 2, 1, 0, 1);
        CurrentTemp = 8'd255;
        clk_to(12); check("post_hold.state", int'(State), 2);
        clk_to(13); drives("post_lock", 4, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
